aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
- Key-load controller and pipeline scheduler for the AES-256 datapath on the MM2S clock.
- Collects a 256-bit key delivered as an 8-word packet on the MM2S control stream.
- Tracks blocks in flight through the AES pipeline and stalls new data so a key change never corrupts an in-flight block.
- Presents a stable key plus a data gate; the top level ANDs the gate into m_axis_mm2s_tready.

Parameters:
- C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH, 32: control stream word width; only 32 is supported.
- C_KEY_WORDS, 8: number of words per key packet (256/32).
- C_CNT_WIDTH, 6: in-flight counter width; must hold AES pipeline depth (31) plus FIFO slack.

Ports:
- m_axi_mm2s_aclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- m_axis_mm2s_cntrl_tdata  in  32  key word.
- m_axis_mm2s_cntrl_tkeep  in  4  byte enables; must be 4'hF.
- m_axis_mm2s_cntrl_tvalid  in  1  control word valid.
- m_axis_mm2s_cntrl_tlast  in  1  last word of key packet.
- m_axis_mm2s_cntrl_tready  out  1  control word accepted.
- blk_accept  in  1  one-cycle pulse per data beat entering the AES pipeline (mm2s handshake).
- blk_done  in  1  one-cycle pulse per result written to the output FIFO.
- data_gate  out  1  permits MM2S data handshakes.
- aes_key  out  256  committed key; word 0 in [255:224].
- key_valid  out  1  a key has been committed since reset.
- key_gen  out  8  count of commits, wraps 255->0.
- in_flight  out  C_CNT_WIDTH  blocks in the pipeline.
- key_err  out  1  one-cycle pulse on a malformed packet or counter underflow.

Behaviour:
- Reset values: state IDLE, aes_key 0, key_valid 0, key_gen 0, in_flight 0, key_err 0, shadow key and word count 0. data_gate and cntrl_tready are low while rst is high.
- States and transitions:
  - IDLE: no key yet. tready=1. A first accepted word goes to LOAD.
  - LOAD: collect words into the shadow register, MSB word first (word k goes to bits [255-32k -: 32]).
    - tlast with word count 8 and every tkeep=4'hF: go to DRAIN.
    - tlast at count ≠8, a 9th word without tlast, or any tkeep≠4'hF: discard the shadow, pulse key_err, return to RUN if key_valid else IDLE. After a 9th-word error, absorb words until tlast before returning.
  - DRAIN: tready=0 and data_gate=0. When in_flight==0, then on the next edge: aes_key<=shadow, key_valid<=1, key_gen+1, go to RUN. If already 0 on entry, this commit takes one cycle.
  - RUN: tready=1. An accepted word goes to LOAD. The old key stays active while loading.
- Gating:
  - data_gate = key_valid && state!=DRAIN, decoded from registered state with no input combinational path.
  - A blk_accept in the final LOAD cycle is legal and is counted before the drain completes.
- in_flight:
  - +1 on blk_accept, -1 on blk_done; no change when both occur in the same cycle.
  - blk_done alone at 0: counter stays 0 and key_err pulses.
  - Overflow is a system error; the counter saturates at all-ones.
- key_err and an error return may coincide with an in_flight update; both take effect.
- aes_key changes only at commit, with 0 cycles latency from the commit edge.
- rst mid-LOAD or mid-DRAIN discards the shadow key and any pending commit.

Decomposition:
- Shared package aes_pkg:
  - state encoding (IDLE, LOAD, DRAIN, RUN);
  - C_KEY_WORDS;
  - AES_PIPE_DEPTH=31;
  - key width 256.
- One natural sub-module, aes_inflight_cnt: up/down counter with underflow flag and saturation.
- The FSM and shadow register stay in aes_key_sched.

Test Plan:
- Reset then 8 words 32'h00010203..32'h1C1D1E1F with tlast on word 8 → key_valid=1 two cycles after tlast, aes_key=256'h00010203…1C1D1E1F, key_gen=1.
- Key A committed, 5 blk_accept pulses, then key B sent → data_gate=0 from the cycle after B's tlast until 5 blk_done pulses arrive; aes_key switches to B the cycle after in_flight reaches 0; no accept occurs while the gate is low.
- Packet of 7 words with tlast → key_err pulses once, aes_key unchanged, state returns to RUN, data_gate stays 1.
- 10-word packet (tlast on word 10) → one key_err pulse, all 10 words absorbed with tready=1, key unchanged.
- blk_accept and blk_done asserted in the same cycle with in_flight=3 → stays 3. blk_done at in_flight=0 → stays 0, key_err pulses.
- rst asserted during DRAIN with in_flight=4 → next cycle state IDLE, in_flight=0, key_valid=0, aes_key=0, data_gate=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 key-load path.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;
    localparam int C_KEY_WORDS    = 8;
    localparam int AES_PIPE_DEPTH = 31;
    localparam int KEY_W          = 256;
endpackage

// File: rtl/aes_key_sched_if.sv
// MM2S control stream carrying key words into the scheduler.
interface aes_key_sched_if #(parameter int W = 32);
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tvalid;
    logic           tlast;
    logic           tready;
    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/aes_inflight_cnt.sv
// Up/down count of blocks inside the AES pipeline.
module aes_inflight_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         uflow
);
    assign uflow = dec && !inc && (cnt == '0);

    // Saturate rather than wrap; the floor holds at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/aes_key_sched.sv
// Collects 256-bit keys and swaps them only once the AES pipeline is empty.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
    parameter int C_KEY_WORDS = aes_pkg::C_KEY_WORDS,
    parameter int C_CNT_WIDTH = $clog2(AES_PIPE_DEPTH + 1) + 1
) (
    input  logic                   m_axi_mm2s_aclk,
    input  logic                   rst,
    aes_key_sched_if.slave         m_axis_mm2s_cntrl,
    input  logic                   blk_accept,
    input  logic                   blk_done,
    output logic                   data_gate,
    output logic [KEY_W-1:0]       aes_key,
    output logic                   key_valid,
    output logic [7:0]             key_gen,
    output logic [C_CNT_WIDTH-1:0] in_flight,
    output logic                   key_err
);
    localparam int W = C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH;
    localparam logic [3:0] LAST_IDX = 4'(C_KEY_WORDS);

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [3:0]       wcnt;
    logic [3:0]       nxt_cnt;
    logic             absorb;
    logic             acc;
    logic             keep_ok;
    logic             uflow;
    state_t           ret;

    assign m_axis_mm2s_cntrl.tready = !rst && (state != DRAIN);
    assign data_gate = !rst && key_valid && (state != DRAIN);

    assign acc     = m_axis_mm2s_cntrl.tvalid && m_axis_mm2s_cntrl.tready;
    assign keep_ok = (m_axis_mm2s_cntrl.tkeep == '1);
    assign nxt_cnt = wcnt + 4'd1;
    assign ret     = key_valid ? RUN : IDLE;

    aes_inflight_cnt #(.W(C_CNT_WIDTH)) u_cnt (
        .clk   (m_axi_mm2s_aclk),
        .rst   (rst),
        .inc   (blk_accept),
        .dec   (blk_done),
        .cnt   (in_flight),
        .uflow (uflow)
    );

    always_ff @(posedge m_axi_mm2s_aclk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            wcnt      <= '0;
            absorb    <= 1'b0;
            aes_key   <= '0;
            key_valid <= 1'b0;
            key_gen   <= '0;
            key_err   <= 1'b0;
        end else begin
            key_err <= uflow;
            unique case (state)
                IDLE, RUN, LOAD: begin
                    if (acc) begin
                        if (absorb) begin
                            if (m_axis_mm2s_cntrl.tlast) begin
                                absorb <= 1'b0;
                                state  <= ret;
                            end
                        end else if (!keep_ok ||
                                     (m_axis_mm2s_cntrl.tlast &&
                                      nxt_cnt != LAST_IDX)) begin
                            key_err <= 1'b1;
                            shadow  <= '0;
                            wcnt    <= '0;
                            state   <= ret;
                        end else if (nxt_cnt > LAST_IDX) begin
                            // Overlong packet: swallow the rest up to tlast.
                            key_err <= 1'b1;
                            shadow  <= '0;
                            wcnt    <= '0;
                            absorb  <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            shadow <= {shadow[KEY_W-W-1:0],
                                       m_axis_mm2s_cntrl.tdata};
                            wcnt   <= nxt_cnt;
                            state  <= m_axis_mm2s_cntrl.tlast ? DRAIN : LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (in_flight == '0) begin
                        aes_key   <= shadow;
                        key_valid <= 1'b1;
                        key_gen   <= key_gen + 8'd1;
                        wcnt      <= '0;
                        state     <= RUN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched.sv
// Directed checks for key loading, drain gating, errors and reset.
module tb_aes_key_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_req = 1'b0;
    logic         blk_accept;
    logic         blk_done = 1'b0;
    logic         data_gate;
    logic [255:0] aes_key;
    logic         key_valid;
    logic [7:0]   key_gen;
    logic [5:0]   in_flight;
    logic         key_err;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           err_cnt = 0;
    int           e0;

    localparam logic [255:0] KEY_A =
        256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
    localparam logic [255:0] KEY_B =
        256'hB0000000_B0000001_B0000002_B0000003_B0000004_B0000005_B0000006_B0000007;

    aes_key_sched_if #(.W(32)) cif ();

    assign blk_accept = data_req && data_gate;

    aes_key_sched dut (
        .m_axi_mm2s_aclk   (clk),
        .rst               (rst),
        .m_axis_mm2s_cntrl (cif),
        .blk_accept        (blk_accept),
        .blk_done          (blk_done),
        .data_gate         (data_gate),
        .aes_key           (aes_key),
        .key_valid         (key_valid),
        .key_gen           (key_gen),
        .in_flight         (in_flight),
        .key_err           (key_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_err) err_cnt++;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic last);
        cif.tdata  = d;
        cif.tkeep  = 4'hF;
        cif.tvalid = 1'b1;
        cif.tlast  = last;
        chk("word_tready", cif.tready, 1);
        tick();
        cif.tvalid = 1'b0;
        cif.tlast  = 1'b0;
    endtask

    task automatic put_key(input logic [255:0] k);
        logic [255:0] s;
        s = k;
        for (int i = 0; i < 8; i++) begin
            put(s[255:224], i == 7);
            s = s << 32;
        end
    endtask

    initial begin
        cif.tdata = '0; cif.tkeep = 4'hF;
        cif.tvalid = 1'b0; cif.tlast = 1'b0;
        tick();
        chk("rst_gate", data_gate, 0);
        chk("rst_tready", cif.tready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_key", aes_key, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_gen", key_gen, 0);
        chk("rst_flt", in_flight, 0);
        chk("rst_err", key_err, 0);
        chk("idle_tready", cif.tready, 1);
        chk("idle_gate", data_gate, 0);

        // First key: commit two cycles after tlast.
        put_key(KEY_A);
        chk("a_drain_kv", key_valid, 0);
        chk("a_drain_tready", cif.tready, 0);
        tick();
        chk("a_kv", key_valid, 1);
        chk("a_key", aes_key, KEY_A);
        chk("a_gen", key_gen, 1);
        chk("a_gate", data_gate, 1);

        // Five blocks in flight, then key B with a beat in its last cycle.
        data_req = 1'b1;
        repeat (5) tick();
        data_req = 1'b0;
        chk("flt5", in_flight, 5);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) data_req = 1'b1;
            put(32'hB000_0000 + 32'(i), i == 7);
        end
        chk("b_flt6", in_flight, 6);
        chk("b_gate0", data_gate, 0);
        chk("b_tready0", cif.tready, 0);
        for (int i = 0; i < 6; i++) begin
            blk_done = 1'b1;
            tick();
            chk("b_hold_gate", data_gate, 0);
            chk("b_hold_key", aes_key, KEY_A);
        end
        blk_done = 1'b0;
        chk("b_flt0", in_flight, 0);
        tick();
        data_req = 1'b0;
        chk("b_key", aes_key, KEY_B);
        chk("b_gen", key_gen, 2);
        chk("b_gate1", data_gate, 1);
        tick();
        chk("b_flt_end", in_flight, 0);

        // Short packet.
        e0 = err_cnt;
        for (int i = 0; i < 7; i++) put(32'hC000_0000 + 32'(i), i == 6);
        chk("short_err", key_err, 1);
        tick();
        chk("short_err_once", err_cnt - e0, 1);
        chk("short_key", aes_key, KEY_B);
        chk("short_gate", data_gate, 1);
        chk("short_tready", cif.tready, 1);

        // Overlong packet: one error, every word absorbed.
        e0 = err_cnt;
        for (int i = 0; i < 10; i++) put(32'hD000_0000 + 32'(i), i == 9);
        tick();
        chk("long_err_once", err_cnt - e0, 1);
        chk("long_key", aes_key, KEY_B);
        chk("long_gen", key_gen, 2);
        chk("long_gate", data_gate, 1);

        // Counter: simultaneous up/down, then underflow.
        data_req = 1'b1;
        repeat (3) tick();
        chk("cnt3", in_flight, 3);
        blk_done = 1'b1;
        tick();
        chk("cnt_both", in_flight, 3);
        data_req = 1'b0;
        repeat (3) tick();
        chk("cnt_down", in_flight, 0);
        e0 = err_cnt;
        tick();
        blk_done = 1'b0;
        chk("uflow_cnt", in_flight, 0);
        chk("uflow_err", key_err, 1);
        tick();
        chk("uflow_once", err_cnt - e0, 1);

        // Reset while draining with blocks outstanding.
        data_req = 1'b1;
        repeat (4) tick();
        data_req = 1'b0;
        put_key(KEY_A);
        chk("d_flt4", in_flight, 4);
        chk("d_gate", data_gate, 0);
        rst = 1'b1;
        tick();
        chk("d_rst_flt", in_flight, 0);
        chk("d_rst_kv", key_valid, 0);
        chk("d_rst_key", aes_key, 0);
        chk("d_rst_gate", data_gate, 0);
        chk("d_rst_gen", key_gen, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("d_idle_tready", cif.tready, 1);
        chk("d_idle_kv", key_valid, 0);
        chk("d_idle_key", aes_key, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
